// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB-first, optional even
// parity, stop bit. The completed frame is held in a valid/ready output stage.
module sipo_frame_rx #(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              bit_en,
  input  logic              sin,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              par_err,
  output logic              frm_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_bad_q, par_bad_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              par_err_q, par_err_d;
  logic              frm_err_q, frm_err_d;
  logic              overrun_q, overrun_d;
  logic              completing;
  logic              transfer;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    overrun_d  = 1'b0;
    completing = 1'b0;
    transfer   = rx_valid_q & rx_ready;

    if (bit_en) begin
      unique case (state_q)
        IDLE: begin
          if (!sin) begin
            state_d   = DATA;
            count_d   = '0;
            par_bad_d = 1'b0;
          end
        end
        DATA: begin
          shift_d[count_q] = sin;
          count_d          = count_q + CW'(1);
          if (count_q == CW'(DATA_W - 1)) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          par_bad_d = (^shift_q) ^ sin;
          state_d   = STOP;
        end
        STOP: begin
          state_d    = IDLE;
          completing = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    // A new frame may only replace the held one if it is leaving this edge.
    if (completing) begin
      if (!rx_valid_q || transfer) begin
        rx_data_d  = shift_q;
        par_err_d  = PARITY_EN ? par_bad_q : 1'b0;
        frm_err_d  = ~sin;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (transfer) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      count_q    <= '0;
      shift_q    <= '0;
      par_bad_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      par_bad_q  <= par_bad_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign par_err  = par_err_q;
  assign frm_err  = frm_err_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Bench for sipo_frame_rx: frames are driven bit by bit, expected frames are
// queued when sent and compared whenever the receiver hands one over.
module tb_sipo_frame_rx;

  logic       clk = 1'b0;
  logic       rstn, bit_en, sin, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, par_err, frm_err, overrun, busy;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } frame_t;

  frame_t exp_q[$];
  int     errors = 0;
  int     checks = 0;
  int     ovr_cnt = 0;
  int     busy_cnt = 0;

  sipo_frame_rx #(.DATA_W(8), .PARITY_EN(1'b1)) dut (
    .clk(clk), .rstn(rstn), .bit_en(bit_en), .sin(sin),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .par_err(par_err), .frm_err(frm_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // One clock: a handshake seen just before the edge is a delivered frame.
  task automatic tick();
    frame_t e;
    if (rx_valid && rx_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame: got data=%h perr=%b ferr=%b, none expected",
                 rx_data, par_err, frm_err);
      end else begin
        e = exp_q.pop_front();
        if ({rx_data, par_err, frm_err} !== {e.data, e.perr, e.ferr}) begin
          errors++;
          $display("FAIL delivered_frame: got data=%h perr=%b ferr=%b, want data=%h perr=%b ferr=%b",
                   rx_data, par_err, frm_err, e.data, e.perr, e.ferr);
        end
      end
    end
    @(posedge clk);
    #1;
    if (overrun) ovr_cnt++;
    if (busy) busy_cnt++;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop,
                            input int period, input bit push, input bit ready_at_stop);
    logic [10:0] bits;
    frame_t      e;
    bits = {stop, (^d) ^ par_flip, d, 1'b0};
    if (push) begin
      e.data = d; e.perr = par_flip; e.ferr = ~stop;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 11; i++) begin
      sin    = bits[i];
      bit_en = 1'b1;
      if (i == 10 && ready_at_stop) rx_ready = 1'b1;
      tick();
      bit_en = 1'b0;
      for (int j = 1; j < period; j++) tick();
    end
    sin    = 1'b1;
    bit_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    rx_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || rx_valid) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || rx_valid) begin
      errors++;
      $display("FAIL drain: %0d frames still expected, rx_valid=%b after %0d cycles, want 0",
               exp_q.size(), rx_valid, n);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0; bit_en = 1'b1; sin = 1'b0; rx_ready = 1'b0;
    tick(); tick();
    checks += 6;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    if (par_err !== 1'b0)  begin errors++; $display("FAIL reset_perr: got %b want 0", par_err); end
    if (frm_err !== 1'b0)  begin errors++; $display("FAIL reset_ferr: got %b want 0", frm_err); end
    if (overrun !== 1'b0)  begin errors++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rstn = 1'b1; sin = 1'b1; bit_en = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    rx_ready = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b1, 1, 1'b1, 1'b0);
    checks += 3;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", rx_valid); end
    if (rx_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", rx_data); end
    if ({par_err, frm_err} !== 2'b00) begin
      errors++; $display("FAIL basic_flags: got %b%b want 00", par_err, frm_err);
    end
    repeat (5) tick();
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin
      errors++; $display("FAIL basic_hold: got valid=%b data=%h want 1 a5", rx_valid, rx_data);
    end
    drain();
  endtask

  task automatic test_parity();
    rx_ready = 1'b0;
    send_frame(8'hA5, 1'b1, 1'b1, 1, 1'b1, 1'b0);
    checks++;
    if ({rx_data, par_err, frm_err} !== {8'hA5, 1'b1, 1'b0}) begin
      errors++; $display("FAIL parity_err: got data=%h perr=%b ferr=%b want a5 1 0",
                         rx_data, par_err, frm_err);
    end
    drain();
  endtask

  task automatic test_framing();
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    checks += 2;
    if ({rx_data, par_err, frm_err} !== {8'h3C, 1'b0, 1'b1}) begin
      errors++; $display("FAIL framing_err: got data=%h perr=%b ferr=%b want 3c 0 1",
                         rx_data, par_err, frm_err);
    end
    if (busy !== 1'b0) begin errors++; $display("FAIL framing_idle: busy=%b want 0", busy); end
    drain();
  endtask

  task automatic test_back_to_back();
    rx_ready = 1'b0; ovr_cnt = 0;
    send_frame(8'h11, 1'b0, 1'b1, 1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    checks += 2;
    if (rx_data !== 8'h11) begin errors++; $display("FAIL b2b_kept: got %h want 11", rx_data); end
    if (ovr_cnt !== 1) begin errors++; $display("FAIL b2b_overrun: got %0d pulses want 1", ovr_cnt); end
    drain();
    ovr_cnt = 0; rx_ready = 1'b1;
    send_frame(8'h11, 1'b0, 1'b1, 1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1, 1'b1, 1'b0);
    drain();
    checks++;
    if (ovr_cnt !== 0) begin errors++; $display("FAIL b2b_ready_ovr: got %0d pulses want 0", ovr_cnt); end
    rx_ready = 1'b0; ovr_cnt = 0;
    send_frame(8'h33, 1'b0, 1'b1, 1, 1'b1, 1'b0);
    send_frame(8'h44, 1'b0, 1'b1, 1, 1'b1, 1'b1);
    checks += 2;
    if (rx_valid !== 1'b1 || rx_data !== 8'h44) begin
      errors++; $display("FAIL same_edge_load: got valid=%b data=%h want 1 44", rx_valid, rx_data);
    end
    if (ovr_cnt !== 0) begin errors++; $display("FAIL same_edge_ovr: got %0d pulses want 0", ovr_cnt); end
    drain();
  endtask

  task automatic test_slow_strobe();
    rx_ready = 1'b0; busy_cnt = 0;
    send_frame(8'hF0, 1'b0, 1'b1, 4, 1'b1, 1'b0);
    checks += 2;
    if (rx_data !== 8'hF0) begin errors++; $display("FAIL slow_data: got %h want f0", rx_data); end
    if (busy_cnt !== 40) begin errors++; $display("FAIL slow_busy: got %0d cycles want 40", busy_cnt); end
    drain();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'h5A;
    rx_ready = 1'b1; ovr_cnt = 0;
    sin = 1'b0; bit_en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin sin = d[i]; tick(); end
    rstn = 1'b0; sin = 1'b1;
    tick();
    rstn = 1'b1; bit_en = 1'b0;
    checks++;
    if (busy !== 1'b0 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got busy=%b valid=%b want 0 0", busy, rx_valid);
    end
    send_frame(8'h5A, 1'b0, 1'b1, 1, 1'b1, 1'b0);
    drain();
    rx_ready = 1'b0;
    send_frame(8'h77, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL pending_drop: got valid=%b want 0", rx_valid); end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_back_to_back();
    test_slow_strobe();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
